// File: rtl/receiver_buffer.sv
// Byte-to-block assembler (16 bytes, first byte in [127:120]) feeding a show-ahead block FIFO.
// Optional macro RX_TIMEOUT_EN enables an inter-byte timeout that discards stale partial blocks.
module receiver_buffer #(
  parameter int DEPTH          = 4,
  parameter int ADDR_W         = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   byte_UART_to_shiftReg,
  input  logic         rx_done,
  input  logic         read_en,
  output logic [127:0] block_buffer_to_aes,
  output logic         empty,
  output logic         full,
  output logic         overflow,
  output logic [3:0]   byte_count,
  output logic         frame_error
);

  logic [ADDR_W:0] wr_ptr_r;
  logic [ADDR_W:0] rd_ptr_r;
  logic [127:0]    mem_r [DEPTH];
  logic [119:0]    shift_r;
  logic [3:0]      count_r;
  logic            overflow_r;

  logic [127:0]    block_s;
  logic            push_s;
  logic            wr_ok_s;
  logic            pop_s;
  logic            empty_s;
  logic            full_s;
  logic            timeout_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]) &&
                   (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]);

  // Completion, push/pop qualification; a full FIFO still accepts a push when popped on the same edge
  always_comb begin
    block_s = {shift_r, byte_UART_to_shiftReg};
    push_s  = rx_done && (count_r == 4'd15);
    pop_s   = read_en && !empty_s;
    if (push_s) begin
      wr_ok_s = !full_s || read_en;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_r;
  logic             frame_error_r;

  // An arriving byte always beats the terminal count
  assign timeout_s = !rx_done && (count_r != 4'd0) &&
                     (idle_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Idle counter: runs only while a partial block is pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_r <= '0;
    end else if (rx_done || timeout_s || (count_r == 4'd0)) begin
      idle_r <= '0;
    end else begin
      idle_r <= idle_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // One-cycle frame error pulse on timeout discard
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_error_r <= 1'b0;
    end else begin
      frame_error_r <= timeout_s;
    end
  end

  assign frame_error = frame_error_r;
`else
  assign timeout_s   = 1'b0;
  assign frame_error = 1'b0;
`endif

  // Assembler: shift in bytes, count wraps to 0 on the completing byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_r <= '0;
      count_r <= 4'd0;
    end else if (rx_done) begin
      shift_r <= {shift_r[111:0], byte_UART_to_shiftReg};
      count_r <= count_r + 4'd1;
    end else if (timeout_s) begin
      shift_r <= '0;
      count_r <= 4'd0;
    end else begin
      shift_r <= shift_r;
      count_r <= count_r;
    end
  end

  // Block storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_ok_s) begin
      mem_r[wr_ptr_r[ADDR_W-1:0]] <= block_s;
    end
  end

  // Pointers with wrap bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{ADDR_W{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  // Sticky drop indicator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (push_s && !wr_ok_s) begin
      overflow_r <= 1'b1;
    end
  end

  assign block_buffer_to_aes = mem_r[rd_ptr_r[ADDR_W-1:0]];
  assign empty               = empty_s;
  assign full                = full_s;
  assign overflow            = overflow_r;
  assign byte_count          = count_r;

endmodule

// File: doc/receiver_buffer.md
Name: receiver_buffer

Overview:
- Receive-side counterpart of the UART transmit path. Collects bytes from the UART receiver into 128-bit blocks, 16 bytes per block.
- Queues the completed blocks in a block FIFO.
- The control block between comm and AES pops the blocks and feeds them to the AES core.
- The block has two stages: a byte-to-block assembler (shift register plus counter) followed by a show-ahead FIFO.

Parameters:
- DEPTH, 4, number of 128-bit block entries in the FIFO. Must be a power of two, at least 2.
- ADDR_W, 2, equals log2(DEPTH). Pointers are ADDR_W+1 bits wide, and the extra bit is the wrap bit.
- TIMEOUT_CYCLES, 50000, inter-byte timeout in clk cycles. Used only with RX_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- byte_UART_to_shiftReg  input  8  received byte from UART rx. Valid only when rx_done=1.
- rx_done  input  1  one-cycle strobe: a byte is valid this cycle.
- read_en  input  1  pop request from the control block.
- block_buffer_to_aes  output  128  head-of-FIFO block, show-ahead.
- empty  output  1  FIFO holds no blocks.
- full  output  1  FIFO holds DEPTH blocks.
- overflow  output  1  sticky: a completed block was dropped.
- byte_count  output  4  bytes collected in the current partial block, 0..15.
- frame_error  output  1  one-cycle pulse on timeout discard. Tied to 0 without RX_TIMEOUT_EN.

Behaviour:
- Reset (async, active-high) values:
  - byte_count=0, shift register=0, FIFO pointers=0, all FIFO entries=0.
  - empty=1, full=0, overflow=0, frame_error=0, block_buffer_to_aes=0.
- Assembler:
  - On each clk edge with rx_done=1: shift_reg <= {shift_reg[119:0], byte_UART_to_shiftReg}, byte_count increments.
  - The first received byte ends in [127:120]. This matches the transmit side, which sends MSB byte first.
- Block completion:
  - Occurs on the edge where rx_done=1 and byte_count=15.
  - The block {shift_reg[119:0], byte} is written into the FIFO on that same edge, with no extra cycle.
  - byte_count wraps to 0 on the same edge.
  - A byte arriving in the very next cycle becomes byte 0 of the next block. No bytes are lost between blocks.
- Write rules:
  - The write succeeds if the FIFO is not full, or if it is full and read_en=1 in the same cycle (simultaneous pop and push).
  - Otherwise the block is dropped and overflow is set to 1. overflow stays set until reset.
  - Pointers and contents are unchanged by a dropped block.
- Read rules:
  - block_buffer_to_aes = mem[rd_ptr] whenever empty=0. With no prior pop, the first written block appears on the edge after its 16th byte.
  - read_en=1 with empty=0 advances rd_ptr on the edge, and the next block (or a stale entry) is presented.
  - read_en=1 with empty=1 is ignored: no pointer change, no error.
- Flags:
  - empty = (wr_ptr==rd_ptr).
  - full = (address bits equal and wrap bits differ).
  - Both are derived from registered pointers, so they update on the edge after the push or pop.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves the occupancy unchanged.
- Wrap-around: pointers increment modulo 2*DEPTH. Entry address = ptr[ADDR_W-1:0].
- Reset mid-block:
  - Discards the partial block and all queued blocks.
  - Clears overflow.
  - No spurious write occurs on deassertion.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined:
  - An idle counter runs while byte_count != 0. It is cleared on every rx_done.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_done, byte_count is cleared to 0, the partial block is discarded (no FIFO write), and frame_error pulses high for exactly 1 cycle.
  - If rx_done coincides with the terminal count, the byte wins: it is accepted and there is no timeout.
  - The counter is held at 0 while byte_count=0.
- Undefined: no counter. frame_error is constant 0. A partial block waits indefinitely.

Test Plan:
1. Send 16 bytes 0x00..0x0F, one every 10 cycles -> empty falls the cycle after the 16th strobe. block_buffer_to_aes=0x000102030405060708090A0B0C0D0E0F. byte_count returns to 0.
2. Send 32 bytes back-to-back (rx_done held high for 32 cycles) -> two blocks queued, no byte lost. Pop twice -> 0x00..0F block, then 0x10..1F block, then empty=1.
3. DEPTH=4: queue 4 blocks -> full=1. Send a 5th block without reading -> overflow=1 and contents unchanged. A 6th block with read_en=1 on its completion edge -> accepted, full stays 1.
4. read_en pulses while empty=1 -> pointers unchanged, empty=1, block output unchanged.
5. Assert reset after 7 bytes with 2 blocks queued -> empty=1, byte_count=0, overflow=0. A following 16 bytes form a clean block.
6. RX_TIMEOUT_EN defined, TIMEOUT_CYCLES=20: send 5 bytes then idle -> frame_error pulses for 1 cycle exactly 20 cycles after the last byte. byte_count=0, no block written. Rerun with a byte arriving at cycle 19 -> no timeout.
